// File: rtl/instruktions_holer_pkg.sv
// Shared constants for the instruction fetch unit: FSM state codes, default
// start address and the NOP word shown on Instruktion before the first delivery.
package instruktions_holer_pkg;

    typedef enum logic [1:0] {
        LEERLAUF  = 2'd0,
        LESEN     = 2'd1,
        VERWERFEN = 2'd2,
        NEUSTART  = 2'd3
    } holer_zustand_e;

    localparam int unsigned STANDARD_ADRESS_BREITE = 32;
    localparam logic [31:0] STANDARD_START_ADRESSE = 32'h0000_0000;
    localparam logic [31:0] NOP_WORT               = 32'h0000_0000;

endpackage

// File: rtl/instruktions_holer.sv
// Instruction fetch unit: owns the PC, reads the word at PC over a request/ready
// handshake and hands it to the decoder with a one-cycle DekodierSignal pulse.
module instruktions_holer
    import instruktions_holer_pkg::*;
#(
    parameter int unsigned                 ADRESS_BREITE = STANDARD_ADRESS_BREITE,
    parameter logic [ADRESS_BREITE-1:0]    START_ADRESSE = ADRESS_BREITE'(STANDARD_START_ADRESSE),
    parameter logic [ADRESS_BREITE-1:0]    PC_SCHRITT    = ADRESS_BREITE'(1)
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     HoleSignal,
    input  logic                     SprungAktiv,
    input  logic [ADRESS_BREITE-1:0] SprungZiel,
    output logic [ADRESS_BREITE-1:0] SpeicherAdresse,
    output logic                     SpeicherLesen,
    input  logic                     SpeicherBereit,
    input  logic [31:0]              SpeicherDaten,
    output logic [31:0]              Instruktion,
    output logic                     DekodierSignal,
    output logic [ADRESS_BREITE-1:0] BefehlsZaehler,
    output logic                     Beschaeftigt
);

    holer_zustand_e             zustand_q;
    logic [ADRESS_BREITE-1:0]   pc_q;
    logic [ADRESS_BREITE-1:0]   adresse_q;
    logic                       lesen_q;
    logic [31:0]                instruktion_q;
    logic                       dekodier_q;
    logic [ADRESS_BREITE-1:0]   befehlsZaehler_q;

    logic [ADRESS_BREITE-1:0]   holAdresse_d;
    logic [ADRESS_BREITE-1:0]   folgePc_d;

    // A redirect presented in the same cycle as a fetch start wins over the PC.
    assign holAdresse_d = SprungAktiv ? SprungZiel : pc_q;
    assign folgePc_d    = adresse_q + PC_SCHRITT;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            zustand_q        <= LEERLAUF;
            pc_q             <= START_ADRESSE;
            adresse_q        <= '0;
            lesen_q          <= 1'b0;
            instruktion_q    <= NOP_WORT;
            dekodier_q       <= 1'b0;
            befehlsZaehler_q <= '0;
        end else begin
            dekodier_q <= 1'b0;
            case (zustand_q)
                LEERLAUF: begin
                    if (SprungAktiv) begin
                        pc_q <= SprungZiel;
                    end
                    if (HoleSignal) begin
                        adresse_q <= holAdresse_d;
                        lesen_q   <= 1'b1;
                        zustand_q <= LESEN;
                    end
                end
                LESEN: begin
                    if (SprungAktiv) begin
                        pc_q <= SprungZiel;
                        if (SpeicherBereit) begin
                            lesen_q   <= 1'b0;
                            zustand_q <= NEUSTART;
                        end else begin
                            zustand_q <= VERWERFEN;
                        end
                    end else if (SpeicherBereit) begin
                        instruktion_q    <= SpeicherDaten;
                        befehlsZaehler_q <= adresse_q;
                        pc_q             <= folgePc_d;
                        dekodier_q       <= 1'b1;
                        lesen_q          <= 1'b0;
                        zustand_q        <= LEERLAUF;
                    end
                end
                // The bus request cannot be withdrawn, so wait for the stale word and drop it.
                VERWERFEN: begin
                    if (SprungAktiv) begin
                        pc_q <= SprungZiel;
                    end
                    if (SpeicherBereit) begin
                        lesen_q   <= 1'b0;
                        zustand_q <= NEUSTART;
                    end
                end
                NEUSTART: begin
                    pc_q      <= holAdresse_d;
                    adresse_q <= holAdresse_d;
                    lesen_q   <= 1'b1;
                    zustand_q <= LESEN;
                end
                default: begin
                    lesen_q   <= 1'b0;
                    zustand_q <= LEERLAUF;
                end
            endcase
        end
    end

    assign SpeicherAdresse = adresse_q;
    assign SpeicherLesen   = lesen_q;
    assign Instruktion     = instruktion_q;
    assign DekodierSignal  = dekodier_q;
    assign BefehlsZaehler  = befehlsZaehler_q;
    assign Beschaeftigt    = (zustand_q != LEERLAUF);

endmodule

// File: tb/tb_instruktions_holer.sv
// Self-checking bench for the fetch unit: a wait-state memory responder plus a
// fetch-level reference model (expected address = PC or latest redirect).
module tb_instruktions_holer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        HoleSignal;
    logic        SprungAktiv;
    logic [31:0] SprungZiel;
    logic [31:0] SpeicherAdresse;
    logic        SpeicherLesen;
    logic        SpeicherBereit;
    logic [31:0] SpeicherDaten;
    logic [31:0] Instruktion;
    logic        DekodierSignal;
    logic [31:0] BefehlsZaehler;
    logic        Beschaeftigt;

    int          total = 0;
    int          bad = 0;
    logic [31:0] modelPc;
    int          waitStates = 0;
    int          lastRises;

    instruktions_holer dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .HoleSignal      (HoleSignal),
        .SprungAktiv     (SprungAktiv),
        .SprungZiel      (SprungZiel),
        .SpeicherAdresse (SpeicherAdresse),
        .SpeicherLesen   (SpeicherLesen),
        .SpeicherBereit  (SpeicherBereit),
        .SpeicherDaten   (SpeicherDaten),
        .Instruktion     (Instruktion),
        .DekodierSignal  (DekodierSignal),
        .BefehlsZaehler  (BefehlsZaehler),
        .Beschaeftigt    (Beschaeftigt)
    );

    always #5 Clock = ~Clock;

    // Program image: address 0 holds the word from the bring-up scenario, the rest is hashed.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0) return 32'hE000_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory answers after waitStates cycles of SpeicherLesen, once per request.
    initial begin
        int cnt;
        cnt = 0;
        SpeicherBereit = 1'b0;
        SpeicherDaten  = 32'h0;
        forever begin
            @(negedge Clock);
            if (Reset || !SpeicherLesen) begin
                SpeicherBereit = 1'b0;
                cnt = 0;
            end else if (!SpeicherBereit) begin
                if (cnt >= waitStates) begin
                    SpeicherBereit = 1'b1;
                    SpeicherDaten  = memWord(SpeicherAdresse);
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idleJump(input logic [31:0] tgt, input string name);
        @(negedge Clock);
        SprungAktiv = 1'b1;
        SprungZiel  = tgt;
        @(negedge Clock);
        SprungAktiv = 1'b0;
        checkOutput($sformatf("%s.idleNoRead", name), {31'h0, SpeicherLesen}, 32'h0);
        modelPc = tgt;
    endtask

    // One complete fetch: optional redirect with the request, optional redirect mid-read,
    // optional ignored HoleSignal while busy.
    task automatic applyStimulus(input int ws, input bit jWithHole, input logic [31:0] jHoleTgt,
                                 input int jumpAt, input logic [31:0] jTgt,
                                 input bit holeDuring, input string name);
        logic [31:0] expAddr, expFirst, firstAddr, segAddr;
        int   pulses, pulseCyc, lesenHigh, rises, cyc;
        bit   midJump, busyOk, addrStable, prevLesen;
        pulses = 0; pulseCyc = 0; lesenHigh = 0; rises = 0; cyc = 0;
        midJump = 0; busyOk = 1; addrStable = 1; prevLesen = 0;
        firstAddr = 32'h0; segAddr = 32'h0;
        waitStates = ws;
        expAddr  = jWithHole ? jHoleTgt : modelPc;
        expFirst = expAddr;

        @(negedge Clock);
        HoleSignal  = 1'b1;
        SprungAktiv = jWithHole;
        SprungZiel  = jHoleTgt;
        while (cyc < ws + 60 && !(pulses > 0 && cyc >= pulseCyc + 2)) begin
            @(negedge Clock);
            cyc++;
            if (cyc == 1) firstAddr = SpeicherAdresse;
            if (SpeicherLesen) begin
                lesenHigh++;
                if (!prevLesen) begin
                    rises++;
                    segAddr = SpeicherAdresse;
                end else if (SpeicherAdresse !== segAddr) begin
                    addrStable = 0;
                end
            end
            prevLesen = SpeicherLesen;
            if (DekodierSignal) begin
                pulses++;
                if (pulses == 1) pulseCyc = cyc;
            end else if (pulses == 0 && !Beschaeftigt) begin
                busyOk = 0;
            end
            SprungAktiv = (jumpAt != 0 && cyc == jumpAt && pulses == 0 && Beschaeftigt);
            SprungZiel  = jTgt;
            if (SprungAktiv) begin
                midJump = 1;
                expAddr = jTgt;
            end
            HoleSignal = holeDuring && Beschaeftigt && pulses == 0;
        end
        HoleSignal  = 1'b0;
        SprungAktiv = 1'b0;

        checkOutput($sformatf("%s.firstAddr", name), firstAddr, expFirst);
        checkOutput($sformatf("%s.pulses", name), pulses, 1);
        checkOutput($sformatf("%s.instr", name), Instruktion, memWord(expAddr));
        checkOutput($sformatf("%s.bz", name), BefehlsZaehler, expAddr);
        checkOutput($sformatf("%s.busy", name), {31'h0, busyOk}, 32'h1);
        checkOutput($sformatf("%s.addrStable", name), {31'h0, addrStable}, 32'h1);
        if (!midJump) begin
            checkOutput($sformatf("%s.latency", name), pulseCyc, ws + 2);
            checkOutput($sformatf("%s.lesenCycles", name), lesenHigh, ws + 1);
        end
        lastRises = rises;
        modelPc   = expAddr + 32'h1;
    endtask

    initial begin
        int          ws, jAt;
        bit          jHole, hDur;
        logic [31:0] t1, t2;

        Reset = 1'b1;
        HoleSignal = 1'b0;
        SprungAktiv = 1'b0;
        SprungZiel = 32'h0;
        modelPc = 32'h0;
        repeat (3) @(negedge Clock);
        checkOutput("reset.adresse", SpeicherAdresse, 32'h0);
        checkOutput("reset.lesen", {31'h0, SpeicherLesen}, 32'h0);
        checkOutput("reset.instr", Instruktion, 32'h0);
        checkOutput("reset.dekod", {31'h0, DekodierSignal}, 32'h0);
        checkOutput("reset.bz", BefehlsZaehler, 32'h0);
        checkOutput("reset.busy", {31'h0, Beschaeftigt}, 32'h0);
        Reset = 1'b0;

        $display("[TB] directed fetches");
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, "first");
        checkOutput("first.word", Instruktion, 32'hE000_0005);
        applyStimulus(3, 0, 32'h0, 0, 32'h0, 0, "wait3");
        applyStimulus(3, 0, 32'h0, 2, 32'h40, 0, "jump40");
        checkOutput("jump40.reads", lastRises, 2);
        checkOutput("jump40.bz", BefehlsZaehler, 32'h40);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, "after40");
        checkOutput("after40.bz", BefehlsZaehler, 32'h41);
        applyStimulus(1, 1, 32'h80, 0, 32'h0, 0, "holeJump80");
        applyStimulus(0, 0, 32'h0, 1, 32'h200, 0, "jumpAtReady");
        idleJump(32'hFFFF_FFFF, "wrapJump");
        applyStimulus(2, 0, 32'h0, 0, 32'h0, 1, "wrapTop");
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, "wrapZero");
        checkOutput("wrapZero.bz", BefehlsZaehler, 32'h0);

        $display("[TB] reset during read");
        waitStates = 10;
        @(negedge Clock);
        HoleSignal = 1'b1;
        @(negedge Clock);
        HoleSignal = 1'b0;
        checkOutput("midReset.lesenBefore", {31'h0, SpeicherLesen}, 32'h1);
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        checkOutput("midReset.lesenDrop", {31'h0, SpeicherLesen}, 32'h0);
        checkOutput("midReset.busy", {31'h0, Beschaeftigt}, 32'h0);
        @(negedge Clock);
        Reset = 1'b0;
        modelPc = 32'h0;
        applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, "afterReset");

        $display("[TB] randomized fetches");
        for (int i = 0; i < 25; i++) begin
            ws    = $urandom_range(0, 5);
            jHole = ($urandom_range(0, 3) == 0);
            jAt   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, ws + 3);
            hDur  = $urandom_range(0, 1);
            t1    = $urandom;
            t2    = $urandom;
            if ($urandom_range(0, 4) == 0) idleJump($urandom, $sformatf("rnd%0d", i));
            applyStimulus(ws, jHole, t1, jAt, t2, hDur, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
